// File: rtl/zero_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// zero_pattern_gen_if
//   Valid/ready pattern stream produced by zero_pattern_gen.
//   Signals:
//     out_data   WIDTH  current pattern, held while out_valid && !out_ready
//     out_valid  1      out_data is valid
//     out_ready  1      sink accepts out_data this cycle
//   Modports:
//     master  pattern source (drives data/valid, samples ready)
//     slave   pattern sink   (samples data/valid, drives ready)
// ----------------------------------------------------------------------------
interface zero_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/zero_pattern_gen.sv
// ----------------------------------------------------------------------------
// zero_pattern_gen
//   Given a requested zero count, streams every WIDTH-bit value that contains
//   exactly that many 0 bits, in ascending order, over a valid/ready stream.
//   One candidate is examined per cycle; a matching candidate is held on the
//   stream until the sink takes it.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     start    in   request a new enumeration (sampled only in IDLE)
//     zeros    in   requested zero count, latched on an accepted start
//     busy     out  high while scanning or emitting
//     done     out  one-cycle pulse when the enumeration completes
//     error    out  one-cycle pulse after a start with zeros > WIDTH
//     total    out  patterns handed over in the current/last run
//     out_if   master side of the pattern stream (data/valid/ready)
// ----------------------------------------------------------------------------
module zero_pattern_gen #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] zeros,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] total,
    zero_pattern_gen_if.master out_if
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] MAX_ZEROS = CNT_W'(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_target;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_error;
    logic [WIDTH-1:0] r_total;

    logic             w_match;
    logic             w_last;
    logic             w_handshake;

    function automatic logic [CNT_W-1:0] f_zero_count(input logic [WIDTH-1:0] value);
        logic [CNT_W-1:0] cnt;
        // NOTE: the accumulator is given a value before the loop; a variable
        // that is only conditionally written in combinational code infers a latch.
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, ~value[i]};
        end
        return cnt;
    endfunction

    assign w_match     = (f_zero_count(r_cand) == r_target);
    // The scan stops on the all-ones candidate instead of letting cand wrap.
    assign w_last      = (r_cand == {WIDTH{1'b1}});
    assign w_handshake = r_valid && out_if.out_ready;

    // NOTE: every register here uses non-blocking assignments so that all
    // next-state decisions read the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cand   <= '0;
            r_target <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_total  <= '0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (zeros <= MAX_ZEROS) begin
                            r_target <= zeros;
                            r_cand   <= '0;
                            r_total  <= '0;
                            r_state  <= S_SCAN;
                        end else begin
                            r_error  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_data  <= r_cand;
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cand  <= r_cand + WIDTH'(1);
                    end
                end
                S_EMIT: begin
                    // Data and valid stay frozen until the sink accepts.
                    if (w_handshake) begin
                        r_total <= r_total + WIDTH'(1);
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cand  <= r_cand + WIDTH'(1);
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = (r_state == S_SCAN) || (r_state == S_EMIT);
    assign done             = (r_state == S_DONE);
    assign error            = r_error;
    assign total            = r_total;
    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;

endmodule
